// File: rtl/kvs_sched_pkg.sv
// Shared types, default sizes and helpers for the KVS transfer scheduler.
package kvs_sched_pkg;

  localparam int unsigned DEF_CHUNK_BYTES = 4096;
  localparam int unsigned DEF_BEAT_BYTES  = 64;
  localparam int unsigned MIN_W           = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CPL   = 2'd3
  } sched_state_t;

  // Smaller of two byte counts; callers widen/narrow to their own widths.
  function automatic logic [MIN_W-1:0] min_bytes(input logic [MIN_W-1:0] a,
                                                 input logic [MIN_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/kvs_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above rr_ptr, with wrap.
module kvs_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_c,
  output logic                       any_c
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  int unsigned     pos;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    any_c       = 1'b0;
    pos         = 0;
    idx         = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = (32'(rr_ptr) + i) % NUM_REQ;
      idx = ID_W'(pos);
      if (!any_c && req[idx]) begin
        grant_c[idx] = 1'b1;
        grant_idx_c  = idx;
        any_c        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kvs_xfer_scheduler.sv
// Round-robin job scheduler that splits jobs into boundary-safe chunks for one data mover.
// Optional perf counters are built when KVS_SCHED_PERF_EN is defined.
module kvs_xfer_scheduler
  import kvs_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned SIZE_W      = 32,
  parameter int unsigned CHUNK_BYTES = DEF_CHUNK_BYTES,
  parameter int unsigned BEAT_BYTES  = DEF_BEAT_BYTES
) (
  input  logic                        ap_clk,
  input  logic                        areset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*SIZE_W-1:0]   req_bytes,
  output logic [NUM_REQ-1:0]          cpl_valid,
  output logic                        mv_start,
  output logic [ADDR_W-1:0]           mv_addr,
  output logic [SIZE_W-1:0]           mv_bytes,
  input  logic                        mv_done,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
`ifdef KVS_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_busy_cycles,
  output logic [31:0]                 perf_chunks
`endif
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  sched_state_t      state, next_state;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt, grant_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt, mv_addr_nxt;
  logic [SIZE_W-1:0] remaining, remaining_nxt, mv_bytes_nxt;
  logic              mv_start_nxt, busy_nxt, chunk_load;
  logic [NUM_REQ-1:0] cpl_nxt;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;

  logic [ADDR_W-1:0] sel_addr, src_addr, offset;
  logic [SIZE_W-1:0] sel_bytes, eff_bytes, src_rem, room, chunk;

  kvs_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req         (req_valid),
    .rr_ptr      (rr_ptr),
    .grant_c     (arb_grant),
    .grant_idx_c (arb_idx),
    .any_c       (arb_any)
  );

  // Payload of the requester the arbiter currently selects.
  always_comb begin
    sel_addr  = '0;
    sel_bytes = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_bytes = req_bytes[i*SIZE_W +: SIZE_W];
      end
    end
  end

  // Next chunk comes from the new job in IDLE, else from the in-flight job.
  assign eff_bytes = sel_bytes & ~SIZE_W'(BEAT_BYTES - 1);
  assign src_addr  = (state == S_IDLE) ? sel_addr  : cur_addr;
  assign src_rem   = (state == S_IDLE) ? eff_bytes : remaining;
  assign offset    = src_addr & ADDR_W'(CHUNK_BYTES - 1);
  assign room      = SIZE_W'(CHUNK_BYTES) - SIZE_W'(offset);
  assign chunk     = SIZE_W'(min_bytes(MIN_W'(src_rem), MIN_W'(room)));

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      mv_addr   <= '0;
      mv_bytes  <= '0;
      mv_start  <= 1'b0;
      cpl_valid <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      rr_ptr    <= rr_ptr_nxt;
      grant_id  <= grant_nxt;
      cur_addr  <= cur_addr_nxt;
      remaining <= remaining_nxt;
      mv_addr   <= mv_addr_nxt;
      mv_bytes  <= mv_bytes_nxt;
      mv_start  <= mv_start_nxt;
      cpl_valid <= cpl_nxt;
      busy      <= busy_nxt;
    end
  end

  // Chunk registers load on entry to ISSUE so mv_start lands one cycle after the decision.
  always_comb begin
    next_state    = state;
    req_ready     = '0;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant_id;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    mv_addr_nxt   = mv_addr;
    mv_bytes_nxt  = mv_bytes;
    mv_start_nxt  = 1'b0;
    chunk_load    = 1'b0;
    cpl_nxt       = '0;
    busy_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        if (arb_any && !areset) begin
          req_ready  = arb_grant;
          grant_nxt  = arb_idx;
          rr_ptr_nxt = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
          if (eff_bytes == '0) begin
            next_state = S_CPL;
          end else begin
            next_state = S_ISSUE;
            chunk_load = 1'b1;
          end
        end
      end
      S_ISSUE: next_state = S_WAIT;
      S_WAIT: begin
        if (mv_done) begin
          if (remaining == '0) begin
            next_state = S_CPL;
          end else begin
            next_state = S_ISSUE;
            chunk_load = 1'b1;
          end
        end
      end
      S_CPL:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase

    if (chunk_load) begin
      mv_start_nxt  = 1'b1;
      mv_addr_nxt   = src_addr;
      mv_bytes_nxt  = chunk;
      cur_addr_nxt  = src_addr + ADDR_W'(chunk);
      remaining_nxt = src_rem - chunk;
    end

    if (next_state == S_CPL) begin
      cpl_nxt = NUM_REQ'(1) << grant_nxt;
    end
    busy_nxt = (next_state != S_IDLE);
  end

`ifdef KVS_SCHED_PERF_EN
  // Saturating activity counters.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      perf_busy_cycles <= '0;
      perf_chunks      <= '0;
    end else begin
      if (busy && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
      if (mv_start && (perf_chunks != 32'hFFFF_FFFF)) begin
        perf_chunks <= perf_chunks + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_kvs_xfer_scheduler.sv
// Directed self-checking bench for kvs_xfer_scheduler with a simple mover responder.
module tb_kvs_xfer_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned SIZE_W  = 32;

  typedef struct { int cyc; logic [63:0] addr; logic [31:0] bytes; } start_t;
  typedef struct { int cyc; logic [3:0] v; } evt_t;

  logic                      ap_clk = 1'b0;
  logic                      areset = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*SIZE_W-1:0] req_bytes = '0;
  logic [NUM_REQ-1:0]        cpl_valid;
  logic                      mv_start;
  logic [ADDR_W-1:0]         mv_addr;
  logic [SIZE_W-1:0]         mv_bytes;
  logic                      mv_done = 1'b0;
  logic                      busy;
  logic [1:0]                grant_id;
`ifdef KVS_SCHED_PERF_EN
  logic [31:0]               perf_busy_cycles;
  logic [31:0]               perf_chunks;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_dly = 1;
  bit mover_en = 1'b1;

  start_t start_q[$];
  evt_t   cpl_q[$];
  evt_t   hs_q[$];

  kvs_xfer_scheduler dut (
    .ap_clk    (ap_clk),
    .areset    (areset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_bytes (req_bytes),
    .cpl_valid (cpl_valid),
    .mv_start  (mv_start),
    .mv_addr   (mv_addr),
    .mv_bytes  (mv_bytes),
    .mv_done   (mv_done),
    .busy      (busy),
    .grant_id  (grant_id)
`ifdef KVS_SCHED_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_chunks      (perf_chunks)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  // Event recorder, sampling mid-cycle.
  initial begin
    forever begin
      @(negedge ap_clk);
      cyc = cyc + 1;
      if (mv_start) start_q.push_back('{cyc, mv_addr, mv_bytes});
      if (|cpl_valid) cpl_q.push_back('{cyc, cpl_valid});
      if (|(req_valid & req_ready)) hs_q.push_back('{cyc, req_ready});
    end
  end

  // Mover model: mv_done pulses done_dly cycles after each mv_start.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (mv_start && mover_en) begin
        repeat (done_dly - 1) @(posedge ap_clk);
        @(posedge ap_clk);
        #2 mv_done = 1'b1;
        @(posedge ap_clk);
        #2 mv_done = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    start_q.delete();
    cpl_q.delete();
    hs_q.delete();
  endtask

  task automatic start_job(input int id, input logic [63:0] a, input logic [31:0] b);
    req_addr[id*ADDR_W +: ADDR_W]  = a;
    req_bytes[id*SIZE_W +: SIZE_W] = b;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_hs_drop(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge ap_clk);
      #2;
      if (hs_q.size() >= n) begin
        req_valid = '0;
        ok = 1'b1;
        return;
      end
    end
    req_valid = '0;
  endtask

  task automatic wait_cpl(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge ap_clk);
      #2;
      if (cpl_q.size() >= n) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    req_valid = 4'b0100;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
    end
    #1 req_valid = '0;
    @(posedge ap_clk);
    #2 areset = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (busy !== 1'b0 || mv_start !== 1'b0 || cpl_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl got busy=%b mv_start=%b cpl=%b exp 0/0/0000", busy, mv_start, cpl_valid);
    end
    checks++;
    if (mv_addr !== 64'd0 || mv_bytes !== 32'd0) begin
      failures++; $display("FAIL reset_mv got addr=%h bytes=%0d exp 0/0", mv_addr, mv_bytes);
    end
    checks++;
    if (grant_id !== 2'd0) begin
      failures++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id);
    end
`ifdef KVS_SCHED_PERF_EN
    checks++;
    if (perf_busy_cycles !== 32'd0 || perf_chunks !== 32'd0) begin
      failures++; $display("FAIL reset_perf got busy=%0d chunks=%0d exp 0/0", perf_busy_cycles, perf_chunks);
    end
`endif
  endtask

  task automatic test_round_robin();
    bit ok;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_r;
    clear_logs();
    done_dly = 1;
    @(posedge ap_clk);
    #2;
    for (int i = 0; i < 4; i++) start_job(i, 64'(i * 256), 32'd64);
    wait_hs_drop(5, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rr_handshakes got=%0d exp=5", hs_q.size());
    end
    wait_cpl(5, ok);
    repeat (3) @(posedge ap_clk);
    for (int k = 0; k < 5 && k < hs_q.size(); k++) begin
      exp_r = 4'b0001 << order[k];
      checks++;
      if (hs_q[k].v !== exp_r) begin
        failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, hs_q[k].v, exp_r);
      end
    end
    checks++;
    if (cpl_q.size() !== 5 || start_q.size() !== 5) begin
      failures++; $display("FAIL rr_counts got cpl=%0d starts=%0d exp 5/5", cpl_q.size(), start_q.size());
    end
  endtask

  task automatic test_chunking();
    bit ok;
    logic [63:0] ea [3] = '{64'h1000, 64'h2000, 64'h3000};
    logic [31:0] eb [3] = '{32'd4096, 32'd4096, 32'd1792};
    clear_logs();
    done_dly = 3;
    @(posedge ap_clk);
    #2 start_job(0, 64'h1000, 32'd9984);
    wait_hs_drop(1, ok);
    wait_cpl(1, ok);
    repeat (3) @(posedge ap_clk);
    checks++;
    if (start_q.size() !== 3 || cpl_q.size() !== 1 || hs_q.size() !== 1) begin
      failures++; $display("FAIL chunk_counts got starts=%0d cpl=%0d hs=%0d exp 3/1/1", start_q.size(), cpl_q.size(), hs_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (start_q[k].addr !== ea[k] || start_q[k].bytes !== eb[k]) begin
          failures++; $display("FAIL chunk%0d got (%h,%0d) exp (%h,%0d)", k, start_q[k].addr, start_q[k].bytes, ea[k], eb[k]);
        end
      end
      checks++;
      if (start_q[0].cyc !== hs_q[0].cyc + 1) begin
        failures++; $display("FAIL chunk_first_latency got=%0d exp=1", start_q[0].cyc - hs_q[0].cyc);
      end
      checks++;
      if (start_q[1].cyc !== start_q[0].cyc + 4) begin
        failures++; $display("FAIL chunk_restart_latency got=%0d exp=4", start_q[1].cyc - start_q[0].cyc);
      end
      checks++;
      if (cpl_q[0].v !== 4'b0001 || cpl_q[0].cyc !== start_q[2].cyc + 4) begin
        failures++; $display("FAIL chunk_cpl got v=%b dt=%0d exp v=0001 dt=4", cpl_q[0].v, cpl_q[0].cyc - start_q[2].cyc);
      end
    end
  endtask

  task automatic test_unaligned();
    bit ok;
    clear_logs();
    done_dly = 2;
    @(posedge ap_clk);
    #2 start_job(1, 64'h1F00, 32'd512);
    wait_hs_drop(1, ok);
    wait_cpl(1, ok);
    repeat (3) @(posedge ap_clk);
    checks++;
    if (start_q.size() !== 2 || cpl_q.size() !== 1) begin
      failures++; $display("FAIL unal_counts got starts=%0d cpl=%0d exp 2/1", start_q.size(), cpl_q.size());
    end else begin
      checks++;
      if (start_q[0].addr !== 64'h1F00 || start_q[0].bytes !== 32'd256) begin
        failures++; $display("FAIL unal_chunk0 got (%h,%0d) exp (1f00,256)", start_q[0].addr, start_q[0].bytes);
      end
      checks++;
      if (start_q[1].addr !== 64'h2000 || start_q[1].bytes !== 32'd256) begin
        failures++; $display("FAIL unal_chunk1 got (%h,%0d) exp (2000,256)", start_q[1].addr, start_q[1].bytes);
      end
      checks++;
      if (cpl_q[0].v !== 4'b0010) begin
        failures++; $display("FAIL unal_cpl got=%b exp=0010", cpl_q[0].v);
      end
    end
    checks++;
    if (grant_id !== 2'd1 || busy !== 1'b0) begin
      failures++; $display("FAIL unal_idle got grant_id=%0d busy=%b exp 1/0", grant_id, busy);
    end
  endtask

  task automatic test_zero_and_sub_beat();
    bit ok;
    clear_logs();
    done_dly = 1;
    @(posedge ap_clk);
    #2 start_job(2, 64'h8000, 32'd0);
    wait_hs_drop(1, ok);
    wait_cpl(1, ok);
    repeat (3) @(posedge ap_clk);
    checks++;
    if (hs_q.size() !== 1 || cpl_q.size() !== 1) begin
      failures++; $display("FAIL zero_counts got hs=%0d cpl=%0d exp 1/1", hs_q.size(), cpl_q.size());
    end else begin
      checks++;
      if (cpl_q[0].v !== 4'b0100 || cpl_q[0].cyc !== hs_q[0].cyc + 1) begin
        failures++; $display("FAIL zero_cpl got v=%b dt=%0d exp v=0100 dt=1", cpl_q[0].v, cpl_q[0].cyc - hs_q[0].cyc);
      end
    end
    checks++;
    if (start_q.size() !== 0) begin
      failures++; $display("FAIL zero_no_start got=%0d exp=0", start_q.size());
    end

    clear_logs();
    #1 start_job(3, 64'h40, 32'd100);
    wait_hs_drop(1, ok);
    wait_cpl(1, ok);
    repeat (3) @(posedge ap_clk);
    checks++;
    if (start_q.size() !== 1) begin
      failures++; $display("FAIL sub_count got=%0d exp=1", start_q.size());
    end else begin
      checks++;
      if (start_q[0].addr !== 64'h40 || start_q[0].bytes !== 32'd64) begin
        failures++; $display("FAIL sub_chunk got (%h,%0d) exp (40,64)", start_q[0].addr, start_q[0].bytes);
      end
    end
    checks++;
    if (cpl_q.size() !== 1 || (cpl_q.size() == 1 && cpl_q[0].v !== 4'b1000)) begin
      failures++; $display("FAIL sub_cpl got n=%0d exp n=1 v=1000", cpl_q.size());
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    clear_logs();
    mover_en = 1'b0;
    @(posedge ap_clk);
    #2 start_job(1, 64'h5000, 32'd4096);
    wait_hs_drop(1, ok);
    repeat (2) @(posedge ap_clk);
    #2 areset = 1'b1;
    @(posedge ap_clk);
    #2 areset = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (busy !== 1'b0 || mv_start !== 1'b0 || cpl_valid !== 4'b0000 || grant_id !== 2'd0) begin
      failures++; $display("FAIL rst_mid_ctrl got busy=%b start=%b cpl=%b gid=%0d exp 0/0/0000/0", busy, mv_start, cpl_valid, grant_id);
    end
    checks++;
    if (mv_addr !== 64'd0 || mv_bytes !== 32'd0) begin
      failures++; $display("FAIL rst_mid_mv got addr=%h bytes=%0d exp 0/0", mv_addr, mv_bytes);
    end
    repeat (6) @(posedge ap_clk);
    checks++;
    if (cpl_q.size() !== 0 || start_q.size() !== 1) begin
      failures++; $display("FAIL rst_mid_abandon got cpl=%0d starts=%0d exp 0/1", cpl_q.size(), start_q.size());
    end

    clear_logs();
    mover_en = 1'b1;
    done_dly = 1;
    #2;
    start_job(2, 64'h100, 32'd64);
    start_job(0, 64'h200, 32'd64);
    wait_hs_drop(1, ok);
    wait_cpl(1, ok);
    repeat (3) @(posedge ap_clk);
    checks++;
    if (hs_q.size() !== 1 || (hs_q.size() == 1 && hs_q[0].v !== 4'b0001)) begin
      failures++; $display("FAIL rst_mid_rr_ptr got n=%0d v=%b exp n=1 v=0001", hs_q.size(), (hs_q.size() > 0) ? hs_q[0].v : 4'bx);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
`ifdef KVS_SCHED_PERF_EN
    logic [31:0] pb0, pc0;
    pb0 = perf_busy_cycles;
    pc0 = perf_chunks;
`endif
    clear_logs();
    done_dly = 1;
    @(posedge ap_clk);
    #2 start_job(1, 64'h0, 32'd16384);
    wait_hs_drop(1, ok);
    wait_cpl(1, ok);
    repeat (3) @(posedge ap_clk);
    checks++;
    if (start_q.size() !== 4) begin
      failures++; $display("FAIL b2b_count got=%0d exp=4", start_q.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (start_q[k].cyc !== start_q[k-1].cyc + 2 || start_q[k].addr !== 64'(k * 4096)) begin
          failures++; $display("FAIL b2b_gap%0d got dt=%0d addr=%h exp dt=2 addr=%h", k, start_q[k].cyc - start_q[k-1].cyc, start_q[k].addr, 64'(k * 4096));
        end
      end
    end
`ifdef KVS_SCHED_PERF_EN
    checks++;
    if (perf_chunks - pc0 !== 32'd4) begin
      failures++; $display("FAIL perf_chunks got=%0d exp=4", perf_chunks - pc0);
    end
    checks++;
    if (perf_busy_cycles - pb0 !== 32'd9) begin
      failures++; $display("FAIL perf_busy got=%0d exp=9", perf_busy_cycles - pb0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_chunking();
    test_unaligned();
    test_zero_and_sub_beat();
    test_reset_mid_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
